// File: rtl/crc8_frame_chk.sv
// Receive-side CRC-8 (poly 0x07, init 0, no final xor) frame checker for the redundancy link.
// Reports per-frame status and length, and keeps saturating good/bad frame counters.
module crc8_frame_chk #(
    parameter int unsigned MIN_LEN = 2,
    parameter int unsigned MAX_LEN = 256,
    parameter int unsigned LEN_W   = 9,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic [7:0]       rx_din,
    input  logic             rx_vld,
    input  logic             rx_sop,
    input  logic             rx_eop,
    input  logic             cnt_clr,
    output logic             frm_done,
    output logic [1:0]       frm_sts,
    output logic [LEN_W-1:0] frm_len,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] SAT_L = LEN_W'(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    localparam logic [1:0] STS_OK    = 2'b00;
    localparam logic [1:0] STS_CRC   = 2'b01;
    localparam logic [1:0] STS_LEN   = 2'b10;
    localparam logic [1:0] STS_ABORT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RECV = 2'b01,
        S_DROP = 2'b10
    } state_e;

    function automatic logic [7:0] crc_upd(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] x;
        logic [7:0] nc;
        x     = din ^ crc;
        nc[0] = x[7] ^ x[6] ^ x[0];
        nc[1] = x[6] ^ x[1] ^ x[0];
        nc[2] = x[6] ^ x[2] ^ x[1] ^ x[0];
        nc[3] = x[7] ^ x[3] ^ x[2] ^ x[1];
        nc[4] = x[4] ^ x[3] ^ x[2];
        nc[5] = x[5] ^ x[4] ^ x[3];
        nc[6] = x[6] ^ x[5] ^ x[4];
        nc[7] = x[7] ^ x[6] ^ x[5];
        return nc;
    endfunction

    // Length error outranks CRC error for a frame that completes normally.
    function automatic logic [1:0] end_sts(input logic [LEN_W-1:0] len, input logic [7:0] residue);
        if (len < MIN_L || len > MAX_L) return STS_LEN;
        if (residue != 8'h00)           return STS_CRC;
        return STS_OK;
    endfunction

    state_e           state_q, state_d;
    logic [7:0]       crc_q, crc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             frm_done_q, frm_done_d;
    logic [1:0]       frm_sts_q, frm_sts_d;
    logic [LEN_W-1:0] frm_len_q, frm_len_d;
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             busy_q, busy_d;

    logic             rep_c;
    logic [1:0]       rep_sts_c;
    logic [LEN_W-1:0] rep_len_c;
    logic [LEN_W-1:0] len_inc_c;
    logic [7:0]       crc_nxt_c;
    logic [7:0]       crc_sop_c;

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        len_d     = len_q;
        rep_c     = 1'b0;
        rep_sts_c = STS_OK;
        rep_len_c = len_q;
        len_inc_c = (len_q == SAT_L) ? len_q : len_q + ONE_L;
        crc_nxt_c = crc_upd(crc_q, rx_din);
        crc_sop_c = crc_upd(8'h00, rx_din);

        unique case (state_q)
            S_IDLE: begin
                if (rx_vld && rx_sop) begin
                    if (rx_eop) begin
                        rep_c     = 1'b1;
                        rep_len_c = ONE_L;
                        rep_sts_c = end_sts(ONE_L, crc_sop_c);
                    end else begin
                        state_d = S_RECV;
                        crc_d   = crc_sop_c;
                        len_d   = ONE_L;
                    end
                end
            end
            S_RECV, S_DROP: begin
                if (rx_vld) begin
                    if (rx_sop) begin
                        // Aborting sop also opens the next frame.
                        rep_c     = 1'b1;
                        rep_sts_c = STS_ABORT;
                        rep_len_c = len_q;
                        state_d   = S_RECV;
                        crc_d     = crc_sop_c;
                        len_d     = ONE_L;
                    end else if (rx_eop) begin
                        rep_c     = 1'b1;
                        rep_len_c = len_inc_c;
                        rep_sts_c = (state_q == S_DROP) ? STS_LEN : end_sts(len_inc_c, crc_nxt_c);
                        state_d   = S_IDLE;
                        crc_d     = 8'h00;
                        len_d     = '0;
                    end else begin
                        len_d = len_inc_c;
                        if (state_q == S_RECV) begin
                            crc_d = crc_nxt_c;
                            if (len_inc_c > MAX_L) state_d = S_DROP;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                crc_d   = 8'h00;
                len_d   = '0;
            end
        endcase
    end

    always_comb begin
        frm_done_d = rep_c;
        frm_sts_d  = rep_c ? rep_sts_c : frm_sts_q;
        frm_len_d  = rep_c ? rep_len_c : frm_len_q;
        busy_d     = (state_d != S_IDLE);
        ok_cnt_d   = ok_cnt_q;
        err_cnt_d  = err_cnt_q;
        // Counters move together with the report so they agree with frm_done.
        if (cnt_clr) begin
            ok_cnt_d  = '0;
            err_cnt_d = '0;
        end else if (rep_c) begin
            if (rep_sts_c == STS_OK) begin
                if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + ONE_C;
            end else begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ONE_C;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            state_q    <= S_IDLE;
            crc_q      <= 8'h00;
            len_q      <= '0;
            frm_done_q <= 1'b0;
            frm_sts_q  <= STS_OK;
            frm_len_q  <= '0;
            ok_cnt_q   <= '0;
            err_cnt_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            frm_done_q <= frm_done_d;
            frm_sts_q  <= frm_sts_d;
            frm_len_q  <= frm_len_d;
            ok_cnt_q   <= ok_cnt_d;
            err_cnt_q  <= err_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign frm_done = frm_done_q;
    assign frm_sts  = frm_sts_q;
    assign frm_len  = frm_len_q;
    assign ok_cnt   = ok_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_crc8_frame_chk.sv
// Scoreboard bench for crc8_frame_chk: directed frames push expected reports, a monitor pops and compares.
module tb_crc8_frame_chk;

    localparam int unsigned MIN_LEN = 2;
    localparam int unsigned MAX_LEN = 256;
    localparam int unsigned LEN_W   = 9;
    localparam int unsigned CNT_W   = 3;

    logic             clk_sys = 1'b0;
    logic             rst_sys;
    logic [7:0]       rx_din;
    logic             rx_vld;
    logic             rx_sop;
    logic             rx_eop;
    logic             cnt_clr;
    logic             frm_done;
    logic [1:0]       frm_sts;
    logic [LEN_W-1:0] frm_len;
    logic [CNT_W-1:0] ok_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             busy;

    always #4 clk_sys = ~clk_sys;

    crc8_frame_chk #(
        .MIN_LEN(MIN_LEN),
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_sys (clk_sys),
        .rst_sys (rst_sys),
        .rx_din  (rx_din),
        .rx_vld  (rx_vld),
        .rx_sop  (rx_sop),
        .rx_eop  (rx_eop),
        .cnt_clr (cnt_clr),
        .frm_done(frm_done),
        .frm_sts (frm_sts),
        .frm_len (frm_len),
        .ok_cnt  (ok_cnt),
        .err_cnt (err_cnt),
        .busy    (busy)
    );

    typedef struct packed {
        logic [1:0]       sts;
        logic [LEN_W-1:0] len;
        logic [CNT_W-1:0] ok;
        logic [CNT_W-1:0] err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_rep(input int sts, input int len, input int ok, input int err);
        exp_t e;
        e.sts = 2'(sts);
        e.len = LEN_W'(len);
        e.ok  = CNT_W'(ok);
        e.err = CNT_W'(err);
        sb_q.push_back(e);
    endtask

    task automatic put(input logic [7:0] d, input logic s, input logic e);
        @(negedge clk_sys);
        rx_din = d;
        rx_vld = 1'b1;
        rx_sop = s;
        rx_eop = e;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            rx_vld = 1'b0;
            rx_sop = 1'b0;
            rx_eop = 1'b0;
        end
    endtask

    // Monitor: every frm_done pulse must match the oldest outstanding expectation.
    always @(negedge clk_sys) begin
        if (rst_sys === 1'b1 && frm_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_report: sts=%0d len=%0d with no report expected at %0t",
                         frm_sts, frm_len, $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("frm_sts", int'(frm_sts), int'(mon_e.sts));
                chk("frm_len", int'(frm_len), int'(mon_e.len));
                chk("ok_cnt",  int'(ok_cnt),  int'(mon_e.ok));
                chk("err_cnt", int'(err_cnt), int'(mon_e.err));
            end
        end
    end

    initial begin
        rst_sys = 1'b0;
        rx_din  = 8'h00;
        rx_vld  = 1'b0;
        rx_sop  = 1'b0;
        rx_eop  = 1'b0;
        cnt_clr = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_frm_done", int'(frm_done), 0);
        chk("rst_frm_sts",  int'(frm_sts),  0);
        chk("rst_frm_len",  int'(frm_len),  0);
        chk("rst_ok_cnt",   int'(ok_cnt),   0);
        chk("rst_err_cnt",  int'(err_cnt),  0);
        chk("rst_busy",     int'(busy),     0);
        rst_sys = 1'b1;
        gap(2);

        // Stray byte without sop is ignored in idle.
        put(8'h55, 1'b0, 1'b0);
        gap(1);
        chk("stray_busy", int'(busy), 0);

        // CRC(01 02) = 1B: good frame, then corrupted CRC byte.
        expect_rep(0, 3, 1, 0);
        put(8'h01, 1'b1, 1'b0);
        put(8'h02, 1'b0, 1'b0);
        chk("recv_busy", int'(busy), 1);
        put(8'h1B, 1'b0, 1'b1);
        gap(2);
        expect_rep(1, 3, 1, 1);
        put(8'h01, 1'b1, 1'b0);
        put(8'h02, 1'b0, 1'b0);
        put(8'h1C, 1'b0, 1'b1);
        gap(2);
        chk("idle_busy", int'(busy), 0);

        // Same frames with rx_vld gaps.
        expect_rep(0, 3, 2, 1);
        put(8'h01, 1'b1, 1'b0); gap(1);
        put(8'h02, 1'b0, 1'b0); gap(2);
        put(8'h1B, 1'b0, 1'b1); gap(2);
        expect_rep(1, 3, 2, 2);
        put(8'h01, 1'b1, 1'b0); gap(3);
        put(8'h02, 1'b0, 1'b0); gap(1);
        put(8'h1C, 1'b0, 1'b1); gap(2);

        // Single-byte frame is too short.
        expect_rep(2, 1, 2, 3);
        put(8'h07, 1'b1, 1'b1);
        gap(2);

        // Exactly MAX_LEN zero bytes: residue 0, legal length.
        expect_rep(0, MAX_LEN, 3, 3);
        put(8'h00, 1'b1, 1'b0);
        for (int i = 1; i < int'(MAX_LEN) - 1; i++) put(8'h00, 1'b0, 1'b0);
        put(8'h00, 1'b0, 1'b1);
        gap(2);

        // MAX_LEN+5 bytes: dropped, length saturates at MAX_LEN+1.
        expect_rep(2, MAX_LEN + 1, 3, 4);
        put(8'h00, 1'b1, 1'b0);
        for (int i = 1; i < int'(MAX_LEN) + 4; i++) put(8'h00, 1'b0, 1'b0);
        chk("drop_busy", int'(busy), 1);
        put(8'h00, 1'b0, 1'b1);
        gap(2);

        // Abort by new sop, the aborting byte starts the next frame.
        expect_rep(3, 2, 3, 5);
        expect_rep(0, 2, 4, 5);
        put(8'h01, 1'b1, 1'b0);
        put(8'h02, 1'b0, 1'b0);
        put(8'h01, 1'b1, 1'b0);
        put(8'h07, 1'b0, 1'b1);
        gap(2);

        // Back-to-back frames with no idle cycle.
        expect_rep(0, 3, 5, 5);
        expect_rep(0, 2, 6, 5);
        put(8'h01, 1'b1, 1'b0);
        put(8'h02, 1'b0, 1'b0);
        put(8'h1B, 1'b0, 1'b1);
        put(8'h01, 1'b1, 1'b0);
        put(8'h07, 1'b0, 1'b1);
        gap(2);

        // 3-bit ok counter reaches all-ones and holds.
        expect_rep(0, 2, 7, 5);
        expect_rep(0, 2, 7, 5);
        for (int i = 0; i < 2; i++) begin
            put(8'h01, 1'b1, 1'b0);
            put(8'h07, 1'b0, 1'b1);
        end
        gap(2);

        // cnt_clr held across the report beats the increment.
        expect_rep(0, 2, 0, 0);
        put(8'h01, 1'b1, 1'b0);
        put(8'h07, 1'b0, 1'b1);
        cnt_clr = 1'b1;
        gap(1);
        @(negedge clk_sys);
        cnt_clr = 1'b0;
        gap(1);
        chk("clr_ok_cnt",  int'(ok_cnt),  0);
        chk("clr_err_cnt", int'(err_cnt), 0);

        // Reset mid-frame: no report for the partial frame, counters cleared.
        expect_rep(0, 1, 0, 0);
        sb_q.pop_back();
        expect_rep(1, 3, 1, 1);
        sb_q.pop_back();
        put(8'h01, 1'b1, 1'b0);
        put(8'h02, 1'b0, 1'b0);
        @(negedge clk_sys);
        rx_vld  = 1'b0;
        rx_sop  = 1'b0;
        rx_eop  = 1'b0;
        rst_sys = 1'b0;
        @(negedge clk_sys);
        chk("midrst_busy", int'(busy), 0);
        rst_sys = 1'b1;
        gap(2);
        expect_rep(0, 2, 1, 0);
        put(8'h01, 1'b1, 1'b0);
        put(8'h07, 1'b0, 1'b1);
        gap(5);

        chk("sb_outstanding", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
